sos_measure_scheduler: RTL and testbench
========================================

Name: sos_measure_scheduler

Overview:
Sequences one shared speed-of-sound distance calculator across NUM_CHANNELS speaker/mic channels, one measurement at a time. Per channel it:
- drives the channel-select mux and waits a settle gap so echoes die down;
- pulses the calculator trigger and waits for a result, with timeout and bounded retry;
- stores the delay in a per-channel result bank.

It sits between the system control logic (start/abort) and the calculator instance. Downstream alignment logic reads per-channel delays from it.

Parameters:
NUM_CHANNELS, 4, number of channels measured per sweep (2..16)
CH_W, 4, width of channel index ports; must satisfy 2^CH_W >= NUM_CHANNELS
SETTLE_CYCLES, 4_800_000, clk cycles idle after channel select, before trigger
TIMEOUT_CYCLES, 200_000_000, clk cycles to wait for a result before declaring an attempt failed
MAX_RETRIES, 3, attempts per channel before it is marked failed (>=1)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
start_in  input  1  one-cycle pulse; begins a sweep when idle
abort_in  input  1  level; returns to idle at the next edge
calc_trigger_out  output  1  one-cycle trigger pulse to the calculator
calc_delay_in  input  12  calculator delay result (24 kHz sample count)
calc_delay_valid_in  input  1  calculator valid level (sticky high until its next impulse)
chan_sel_out  output  CH_W  channel currently routed to the calculator
rd_chan_in  input  CH_W  result read address
rd_delay_out  output  12  stored delay for rd_chan_in (registered)
rd_valid_out  output  1  1 if rd_chan_in holds a successful measurement (registered)
busy_out  output  1  high while a sweep is in progress
done_out  output  1  one-cycle pulse when a sweep completes
fail_mask_out  output  NUM_CHANNELS  bit i set if channel i exhausted its retries in the last sweep

Behaviour:
- Reset values:
  - state IDLE; chan_sel_out=0; calc_trigger_out=0; busy_out=0; done_out=0; fail_mask_out=0.
  - All stored delays = 12'hFFF; all valid bits = 0; rd_delay_out=12'hFFF; rd_valid_out=0.
  - Retry, settle and timeout counters = 0; valid edge register = 0.
- Edge detect: valid_q <= calc_delay_valid_in every cycle. A result event is calc_delay_valid_in & ~valid_q, and is honoured only in WAIT. The sticky-high level is never treated as a new result.
- IDLE:
  - start_in=1 -> SETTLE next cycle, with chan_sel_out=0, retry=0, busy_out=1.
  - Starting a sweep clears all valid bits and fail_mask_out; stored delays are kept until overwritten.
- SETTLE: counter increments each cycle. Exactly SETTLE_CYCLES cycles after entry -> TRIGGER.
- TRIGGER: calc_trigger_out=1 for exactly one cycle; timeout counter cleared; -> WAIT.
- WAIT:
  - Result event -> STORE, latching calc_delay_in in the same cycle.
  - Otherwise, when the timeout counter reaches TIMEOUT_CYCLES-1 -> FAIL.
  - A result event and a timeout in the same cycle: the result wins.
- STORE:
  - delay[chan] <= latched value; valid[chan] <= 1.
  - Delay 12'hFFF is a legal stored value; the valid bit disambiguates it from "no result".
  - -> NEXT.
- FAIL:
  - retry+1 < MAX_RETRIES: retry++ and -> SETTLE (same channel).
  - Otherwise: fail_mask_out[chan] <= 1; delay[chan] <= 12'hFFF; valid[chan] <= 0; -> NEXT.
- NEXT:
  - chan == NUM_CHANNELS-1: -> IDLE; done_out=1 for that one cycle; busy_out=0 from the IDLE cycle on; chan_sel_out returns to 0.
  - Otherwise: chan++, retry=0, -> SETTLE.
- abort_in=1 in any non-IDLE state:
  - -> IDLE next cycle; calc_trigger_out=0; no done_out.
  - Results already stored stay valid; channels not yet measured stay invalid.
  - abort_in has priority over every transition, including start_in in IDLE (start ignored while abort_in=1).
- start_in while busy is ignored.
- Read port: 1-cycle latency. rd_chan_in >= NUM_CHANNELS returns 12'hFFF with valid 0. A read of a channel being written in the same cycle returns the old value.
- rst_in asserted mid-sweep: all state returns to reset values at the next edge; no trigger or done pulse is emitted in that cycle.
- Counters are wide enough for their parameter ($clog2(param+1)) and never wrap.

Test Plan:
All scenarios use NUM_CHANNELS=4, SETTLE_CYCLES=8, TIMEOUT_CYCLES=64, MAX_RETRIES=2, with a model calculator raising valid N cycles after trigger.
1. Nominal sweep, delays 100/200/300/400 each returned 20 cycles after trigger -> one trigger per channel, 8 idle cycles before each. done_out pulses once; rd_delay_out(ch2)=300 one cycle after rd_chan_in=2; fail_mask_out=0.
2. Channel 1 never responds -> exactly 2 triggers on channel 1, each followed by 64 WAIT cycles. fail_mask_out=4'b0010; rd ch1 gives 12'hFFF with valid 0; channels 0, 2, 3 valid.
3. Channel 3 times out once, then returns 42 on retry -> rd ch3 gives 42 with valid 1; fail_mask bit 3 = 0.
4. Valid held high from channel 0 into channel 1's WAIT with no new rising edge -> channel 1 is not stored early. A rising edge at timeout cycle 63 is stored, not treated as a failure.
5. abort_in during channel 2's WAIT -> busy_out=0 next cycle; no done_out; ch0 and ch1 valid; ch2 and ch3 invalid. A later start_in clears all valid bits.
6. rst_in asserted in SETTLE of channel 1 -> all outputs at reset values next cycle. A start_in 1 cycle later begins a clean sweep at channel 0.

Source files
------------

// File: rtl/sos_measure_scheduler.sv
// Time-multiplexes one speed-of-sound calculator over NUM_CHANNELS channels and banks the per-channel delays.
// Latency: per channel SETTLE + response + 3 cycles; read port 1 cycle. Backpressure: none; start is ignored while busy, abort wins.
module sos_measure_scheduler #(
    parameter int NUM_CHANNELS   = 4,
    parameter int CH_W           = 4,
    parameter int SETTLE_CYCLES  = 4_800_000,
    parameter int TIMEOUT_CYCLES = 200_000_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    input  logic                    abort_in,
    output logic                    calc_trigger_out,
    input  logic [11:0]             calc_delay_in,
    input  logic                    calc_delay_valid_in,
    output logic [CH_W-1:0]         chan_sel_out,
    input  logic [CH_W-1:0]         rd_chan_in,
    output logic [11:0]             rd_delay_out,
    output logic                    rd_valid_out,
    output logic                    busy_out,
    output logic                    done_out,
    output logic [NUM_CHANNELS-1:0] fail_mask_out
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_TRIGGER,
        S_WAIT,
        S_STORE,
        S_FAIL,
        S_NEXT
    } state_t;

    state_t                  state_q,  state_d;
    logic [CH_W-1:0]         chan_q,   chan_d;
    logic [RTY_W-1:0]        retry_q,  retry_d;
    logic [SET_W-1:0]        settle_q, settle_d;
    logic [TMO_W-1:0]        tmo_q,    tmo_d;
    logic [11:0]             latch_q,  latch_d;
    logic                    trig_q,   trig_d;
    logic                    busy_q,   busy_d;
    logic                    done_q,   done_d;
    logic [NUM_CHANNELS-1:0] fail_q,   fail_d;
    logic [11:0]             dly_q [NUM_CHANNELS];
    logic [11:0]             dly_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] vld_q,    vld_d;
    logic [11:0]             rd_dly_q, rd_dly_d;
    logic                    rd_vld_q, rd_vld_d;
    logic                    vin_q;
    logic                    result_evt;

    // The calculator's valid is sticky; only a fresh rising edge counts as a result.
    assign result_evt = calc_delay_valid_in & ~vin_q;

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        retry_d  = retry_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        latch_d  = latch_q;
        trig_d   = 1'b0;
        done_d   = 1'b0;
        fail_d   = fail_q;
        dly_d    = dly_q;
        vld_d    = vld_q;

        case (state_q)
            S_IDLE: begin
                if (start_in && !abort_in) begin
                    state_d  = S_SETTLE;
                    chan_d   = '0;
                    retry_d  = '0;
                    settle_d = '0;
                    fail_d   = '0;
                    vld_d    = '0;
                end
            end
            S_SETTLE: begin
                if (settle_q == SET_LAST) begin
                    state_d  = S_TRIGGER;
                    settle_d = '0;
                    trig_d   = 1'b1;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_TRIGGER: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (result_evt) begin
                    latch_d = calc_delay_in;
                    state_d = S_STORE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FAIL;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_STORE: begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (chan_q == CH_W'(i)) begin
                        dly_d[i] = latch_q;
                        vld_d[i] = 1'b1;
                    end
                end
                state_d = S_NEXT;
            end
            S_FAIL: begin
                if (retry_q < RTY_LAST) begin
                    retry_d  = retry_q + 1'b1;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end else begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        if (chan_q == CH_W'(i)) begin
                            fail_d[i] = 1'b1;
                            dly_d[i]  = 12'hFFF;
                            vld_d[i]  = 1'b0;
                        end
                    end
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (chan_q == CH_LAST) begin
                    state_d = S_IDLE;
                    chan_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    chan_d   = chan_q + 1'b1;
                    retry_d  = '0;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort freezes the bank and flags as they stand and drops straight to idle.
        if (abort_in && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            chan_d   = '0;
            retry_d  = '0;
            settle_d = '0;
            tmo_d    = '0;
            trig_d   = 1'b0;
            done_d   = 1'b0;
            fail_d   = fail_q;
            dly_d    = dly_q;
            vld_d    = vld_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        rd_dly_d = 12'hFFF;
        rd_vld_d = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (rd_chan_in == CH_W'(i)) begin
                rd_dly_d = dly_q[i];
                rd_vld_d = vld_q[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            chan_q   <= '0;
            retry_q  <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            latch_q  <= '0;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                dly_q[i] <= 12'hFFF;
            end
            vld_q    <= '0;
            rd_dly_q <= 12'hFFF;
            rd_vld_q <= 1'b0;
            vin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            retry_q  <= retry_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            latch_q  <= latch_d;
            trig_q   <= trig_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            dly_q    <= dly_d;
            vld_q    <= vld_d;
            rd_dly_q <= rd_dly_d;
            rd_vld_q <= rd_vld_d;
            vin_q    <= calc_delay_valid_in;
        end
    end

    assign calc_trigger_out = trig_q;
    assign chan_sel_out     = chan_q;
    assign busy_out         = busy_q;
    assign done_out         = done_q;
    assign fail_mask_out    = fail_q;
    assign rd_delay_out     = rd_dly_q;
    assign rd_valid_out     = rd_vld_q;

endmodule

// File: tb/tb_sos_measure_scheduler.sv
// Bench for sos_measure_scheduler: a calculator model answers each trigger from a per-attempt table,
// and sweep outcomes and trigger timing are predicted from the measurement rules.
module tb_sos_measure_scheduler;

    localparam int NCH = 4;
    localparam int CHW = 4;
    localparam int SET = 8;
    localparam int TMO = 64;
    localparam int RTY = 2;

    logic            clk_in;
    logic            rst_in;
    logic            start_in;
    logic            abort_in;
    logic            calc_trigger_out;
    logic [11:0]     calc_delay_in;
    logic            calc_delay_valid_in;
    logic [CHW-1:0]  chan_sel_out;
    logic [CHW-1:0]  rd_chan_in;
    logic [11:0]     rd_delay_out;
    logic            rd_valid_out;
    logic            busy_out;
    logic            done_out;
    logic [NCH-1:0]  fail_mask_out;

    sos_measure_scheduler #(
        .NUM_CHANNELS(NCH), .CH_W(CHW), .SETTLE_CYCLES(SET),
        .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(RTY)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .abort_in(abort_in),
        .calc_trigger_out(calc_trigger_out), .calc_delay_in(calc_delay_in),
        .calc_delay_valid_in(calc_delay_valid_in), .chan_sel_out(chan_sel_out),
        .rd_chan_in(rd_chan_in), .rd_delay_out(rd_delay_out), .rd_valid_out(rd_valid_out),
        .busy_out(busy_out), .done_out(done_out), .fail_mask_out(fail_mask_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Calculator behaviour per (channel, attempt): lat=0 never answers; hold=0 drops valid on trigger.
    int          lat_tbl  [NCH][RTY];
    int          hold_tbl [NCH][RTY];
    logic [11:0] dly_tbl  [NCH][RTY];

    logic [11:0] m_dly [NCH];
    logic        m_vld [NCH];

    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          trig_cyc_q[$];
    int          trig_ch_q[$];
    int          att_seen [NCH];
    int          mon_ch, mon_a, mon_k;
    int          cur_lat, cur_hold, trig_at;
    logic [11:0] cur_dly;
    bit          armed = 0;

    always @(posedge clk_in) begin
        #1;
        cyc++;
        if (done_out === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (calc_trigger_out === 1'b1) begin
            trig_cyc_q.push_back(cyc);
            mon_ch = int'(chan_sel_out);
            trig_ch_q.push_back(mon_ch);
            if (mon_ch < NCH) begin
                mon_a = att_seen[mon_ch];
                att_seen[mon_ch]++;
                if (mon_a >= RTY) mon_a = RTY - 1;
                cur_lat  = lat_tbl[mon_ch][mon_a];
                cur_hold = hold_tbl[mon_ch][mon_a];
                cur_dly  = dly_tbl[mon_ch][mon_a];
                trig_at  = cyc;
                armed    = 1;
                if (cur_hold == 0) calc_delay_valid_in = 1'b0;
            end
        end else if (armed) begin
            mon_k = cyc - trig_at;
            if (cur_hold > 0 && mon_k == cur_hold) calc_delay_valid_in = 1'b0;
            if (cur_lat > 0 && mon_k == cur_lat) begin
                calc_delay_in       = cur_dly;
                calc_delay_valid_in = 1'b1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_att(input int ch, input int a, input int lat, input int hold, input logic [11:0] d);
        lat_tbl[ch][a]  = lat;
        hold_tbl[ch][a] = hold;
        dly_tbl[ch][a]  = d;
    endtask

    task automatic rand_att(input int ch, input int a);
        int r;
        r = $urandom_range(0, 3);
        if (r == 0)      set_att(ch, a, 0, 0, 12'(($urandom_range(0, 4095))));
        else if (r == 1) set_att(ch, a, $urandom_range(TMO + 1, TMO + 6), 0, 12'($urandom_range(0, 4095)));
        else             set_att(ch, a, $urandom_range(1, TMO), 0, 12'($urandom_range(0, 4095)));
    endtask

    task automatic good_att(input int ch);
        for (int a = 0; a < RTY; a++)
            set_att(ch, a, $urandom_range(1, 60), 0, 12'($urandom_range(0, 4095)));
    endtask

    task automatic read_chk(input string tag, input int ch);
        logic [11:0] ed;
        logic        ev;
        rd_chan_in = ch[CHW-1:0];
        tick();
        ed = (ch < NCH) ? m_dly[ch] : 12'hFFF;
        ev = (ch < NCH) ? m_vld[ch] : 1'b0;
        check($sformatf("%s_rd%0d_delay", tag, ch), 32'(rd_delay_out), 32'(ed));
        check($sformatf("%s_rd%0d_valid", tag, ch), 32'(rd_valid_out), 32'(ev));
    endtask

    task automatic clear_log();
        trig_cyc_q.delete();
        trig_ch_q.delete();
        for (int c = 0; c < NCH; c++) att_seen[c] = 0;
    endtask

    task automatic pulse_start(output int sc);
        start_in = 1'b1;
        sc = cyc;
        tick();
        start_in = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input bit mid_start);
        int sc, t, d0, budget, n;
        int ech[$];
        int ecyc[$];
        logic [NCH-1:0] efail;
        clear_log();
        d0 = done_cnt;
        efail = '0;
        for (int c = 0; c < NCH; c++) m_vld[c] = 1'b0;
        pulse_start(sc);
        t = sc + SET + 1;
        for (int c = 0; c < NCH; c++) begin
            for (int a = 0; a < RTY; a++) begin
                ech.push_back(c);
                ecyc.push_back(t);
                if (lat_tbl[c][a] > 0 && lat_tbl[c][a] <= TMO) begin
                    m_dly[c] = dly_tbl[c][a];
                    m_vld[c] = 1'b1;
                    t += lat_tbl[c][a] + SET + 3;
                    break;
                end else if (a < RTY - 1) begin
                    t += TMO + SET + 2;
                end else begin
                    efail[c] = 1'b1;
                    m_dly[c] = 12'hFFF;
                    m_vld[c] = 1'b0;
                    t += TMO + SET + 3;
                end
            end
        end
        budget = 0;
        while (done_cnt == d0 && budget < 4000) begin
            start_in = mid_start && (budget == 30);
            tick();
            budget++;
        end
        start_in = 1'b0;
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(t - SET));
        check({tag, "_busy_at_done"}, 32'(busy_out), 32'd0);
        check({tag, "_chan_sel_at_done"}, 32'(chan_sel_out), 32'd0);
        check({tag, "_fail_mask"}, 32'(fail_mask_out), 32'(efail));
        tick();
        check({tag, "_done_oneshot"}, 32'(done_out), 32'd0);
        n = trig_cyc_q.size();
        check({tag, "_trig_count"}, 32'(n), 32'(ech.size()));
        for (int i = 0; i < n && i < ech.size(); i++) begin
            check($sformatf("%s_trig%0d_chan", tag, i), 32'(trig_ch_q[i]), 32'(ech[i]));
            check($sformatf("%s_trig%0d_cycle", tag, i), 32'(trig_cyc_q[i]), 32'(ecyc[i]));
        end
        for (int c = 0; c < NCH; c++) read_chk(tag, c);
        read_chk(tag, NCH + 1);
        read_chk(tag, 15);
    endtask

    initial begin
        int sc, b, d0;
        rst_in = 1'b1;
        start_in = 1'b0;
        abort_in = 1'b0;
        rd_chan_in = '0;
        calc_delay_in = '0;
        calc_delay_valid_in = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_dly[c] = 12'hFFF;
            m_vld[c] = 1'b0;
            good_att(c);
        end
        repeat (3) tick();
        rst_in = 1'b0;

        check("rst_chan_sel", 32'(chan_sel_out), 32'd0);
        check("rst_trigger", 32'(calc_trigger_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_fail_mask", 32'(fail_mask_out), 32'd0);
        check("rst_rd_delay", 32'(rd_delay_out), 32'hFFF);
        check("rst_rd_valid", 32'(rd_valid_out), 32'd0);
        read_chk("rst", 0);
        read_chk("rst", 3);

        // start together with abort must not launch a sweep
        start_in = 1'b1;
        abort_in = 1'b1;
        tick();
        start_in = 1'b0;
        abort_in = 1'b0;
        check("abort_blocks_start_busy", 32'(busy_out), 32'd0);

        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < RTY; a++) set_att(c, a, 20, 0, 12'(100 * (c + 1)));
        run_sweep("s1", 0);

        for (int c = 0; c < NCH; c++) good_att(c);
        set_att(1, 0, 0, 0, 12'h123);
        set_att(1, 1, 0, 0, 12'h456);
        run_sweep("s2", 0);

        for (int c = 0; c < NCH; c++) good_att(c);
        set_att(3, 0, 0, 0, 12'h777);
        set_att(3, 1, $urandom_range(1, 60), 0, 12'd42);
        run_sweep("s3", 1);

        // channel 0 leaves valid high; channel 1 only answers on the final timeout cycle
        for (int c = 0; c < NCH; c++) good_att(c);
        set_att(0, 0, $urandom_range(1, 60), 0, 12'hFFF);
        set_att(1, 0, TMO, 40, 12'($urandom_range(0, 4095)));
        run_sweep("s4", 0);

        for (int c = 0; c < NCH; c++) good_att(c);
        set_att(2, 0, 0, 0, 12'h0AA);
        set_att(2, 1, 0, 0, 12'h0BB);
        clear_log();
        for (int c = 0; c < NCH; c++) m_vld[c] = 1'b0;
        pulse_start(sc);
        b = 0;
        while (trig_ch_q.size() < 3 && b < 2000) begin
            tick();
            b++;
        end
        check("s5_reached_ch2", 32'(trig_ch_q.size()), 32'd3);
        repeat (5) tick();
        m_dly[0] = dly_tbl[0][0];
        m_vld[0] = 1'b1;
        m_dly[1] = dly_tbl[1][0];
        m_vld[1] = 1'b1;
        d0 = done_cnt;
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("s5_busy_after_abort", 32'(busy_out), 32'd0);
        check("s5_trigger_after_abort", 32'(calc_trigger_out), 32'd0);
        repeat (80) tick();
        check("s5_no_done", 32'(done_cnt - d0), 32'd0);
        check("s5_no_more_triggers", 32'(trig_ch_q.size()), 32'd3);
        check("s5_fail_mask", 32'(fail_mask_out), 32'd0);
        for (int c = 0; c < NCH; c++) read_chk("s5", c);

        for (int c = 0; c < NCH; c++) good_att(c);
        clear_log();
        for (int c = 0; c < NCH; c++) m_vld[c] = 1'b0;
        pulse_start(sc);
        read_chk("s5b", 0);
        read_chk("s5b", 1);
        b = 0;
        while (chan_sel_out != 4'd1 && b < 500) begin
            tick();
            b++;
        end
        check("s6_reached_ch1", 32'(chan_sel_out), 32'd1);
        rst_in = 1'b1;
        tick();
        for (int c = 0; c < NCH; c++) begin
            m_dly[c] = 12'hFFF;
            m_vld[c] = 1'b0;
        end
        check("s6_rst_chan_sel", 32'(chan_sel_out), 32'd0);
        check("s6_rst_trigger", 32'(calc_trigger_out), 32'd0);
        check("s6_rst_busy", 32'(busy_out), 32'd0);
        check("s6_rst_done", 32'(done_out), 32'd0);
        check("s6_rst_fail_mask", 32'(fail_mask_out), 32'd0);
        check("s6_rst_rd_delay", 32'(rd_delay_out), 32'hFFF);
        check("s6_rst_rd_valid", 32'(rd_valid_out), 32'd0);
        rst_in = 1'b0;
        run_sweep("s6", 0);

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < NCH; c++)
                for (int a = 0; a < RTY; a++) rand_att(c, a);
            run_sweep($sformatf("rnd%0d", r), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
